// File: rtl/gc_pkg.sv
// rtl/gc_pkg.sv - shared widths, command encodings and FSM enums for the GameCube poll scheduler
package gc_pkg;

  localparam int GC_CMD_W = 25;
  localparam int GC_LEN_W = 13;

  localparam logic [7:0]  GC_CMD_ID   = 8'h00;
  localparam logic [15:0] GC_CMD_POLL = 16'h4003;

  localparam logic [GC_LEN_W-1:0] GC_LEN_ID   = 13'd9;
  localparam logic [GC_LEN_W-1:0] GC_LEN_POLL = 13'd25;

  localparam logic [GC_CMD_W-1:0] GC_ID_WORD = {16'h0000, GC_CMD_ID, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RX,
    ST_WAIT_PERIOD,
    ST_BACKOFF
  } gc_state_e;

  typedef enum logic {
    GC_KIND_PROBE,
    GC_KIND_POLL
  } gc_kind_e;

  // Poll word is MSB-first with the stop bit in bit 0 and rumble just above it.
  function automatic logic [GC_CMD_W-1:0] gc_poll_word(input logic rumble_bit);
    return {GC_CMD_POLL, 7'h00, rumble_bit, 1'b1};
  endfunction

endpackage

// File: rtl/gc_us_timer.sv
// rtl/gc_us_timer.sv - microsecond prescaler with a loadable 16-bit down-counter and sticky expired flag
module gc_us_timer #(
  parameter int unsigned DIV = 100
) (
  input  logic        clk100mhz,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        expired
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic          tick;

  assign tick = (presc == PW'(DIV - 1));

  // Loading restarts the prescaler so a load of N expires exactly N ticks later.
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      presc   <= '0;
      count   <= load_val;
      expired <= (load_val == 16'd0);
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick && count != 16'd0) begin
        count <= count - 16'd1;
        if (count == 16'd1) expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gc_poll_scheduler.sv
// rtl/gc_poll_scheduler.sv - probe/poll sequencer for the GameCube transmitter; GC_RUMBLE_EN routes rumble into poll words
module gc_poll_scheduler
  import gc_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned POLL_PERIOD_US  = 16000,
  parameter int unsigned RESP_TIMEOUT_US = 400,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic                clk100mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic                rumble,
  output logic [GC_CMD_W-1:0] tx_command,
  output logic [GC_LEN_W-1:0] tx_length,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic                rx_done,
  input  logic                rx_error,
  output logic                poll_valid,
  output logic                link_up,
  output logic [7:0]          err_count
);

  localparam int unsigned US_DIV     = (CLK_HZ >= 1000000) ? CLK_HZ / 1000000 : 1;
  localparam logic [15:0] TX_WIN_LD  = 16'd10;
  localparam logic [15:0] RESP_TO_LD = 16'(RESP_TIMEOUT_US);
  localparam logic [15:0] PERIOD_LD  = 16'(POLL_PERIOD_US);
  localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRIES);

  gc_state_e             state_q, state_d;
  gc_kind_e              kind_q, kind_d;
  logic [7:0]            retry_q, retry_d;
  logic                  seen_busy_q, seen_d;
  logic [GC_CMD_W-1:0]   cmd_d;
  logic [GC_LEN_W-1:0]   len_d;
  logic [7:0]            err_d;
  logic                  start_d, pv_d, link_d, fail;
  logic                  rsp_load, per_load, rsp_expired, per_expired;
  logic [15:0]           rsp_val;
  logic                  rumble_bit;

`ifdef GC_RUMBLE_EN
  assign rumble_bit = rumble;
`else
  assign rumble_bit = rumble & 1'b0;
`endif

  gc_us_timer #(.DIV(US_DIV)) u_rsp_timer (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .load      (rsp_load),
    .load_val  (rsp_val),
    .expired   (rsp_expired)
  );

  gc_us_timer #(.DIV(US_DIV)) u_per_timer (
    .clk100mhz (clk100mhz),
    .reset     (reset),
    .load      (per_load),
    .load_val  (PERIOD_LD),
    .expired   (per_expired)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    retry_d  = retry_q;
    seen_d   = seen_busy_q;
    cmd_d    = tx_command;
    len_d    = tx_length;
    link_d   = link_up;
    err_d    = err_count;
    start_d  = 1'b0;
    pv_d     = 1'b0;
    fail     = 1'b0;
    rsp_load = 1'b0;
    rsp_val  = RESP_TO_LD;
    per_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        link_d  = 1'b0;
        kind_d  = GC_KIND_PROBE;
        retry_d = '0;
        if (enable) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          start_d  = 1'b1;
          cmd_d    = (kind_q == GC_KIND_POLL) ? gc_poll_word(rumble_bit) : GC_ID_WORD;
          len_d    = (kind_q == GC_KIND_POLL) ? GC_LEN_POLL : GC_LEN_ID;
          per_load = 1'b1;
          rsp_load = 1'b1;
          rsp_val  = TX_WIN_LD;
          seen_d   = 1'b0;
          state_d  = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        // The 10 us window only matters until busy has been observed.
        if (tx_busy) begin
          seen_d = 1'b1;
        end else if (seen_busy_q) begin
          rsp_load = 1'b1;
          rsp_val  = RESP_TO_LD;
          state_d  = ST_WAIT_RX;
        end else if (rsp_expired) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_RX: begin
        if (rx_error) begin
          fail = 1'b1;
        end else if (rx_done) begin
          retry_d = '0;
          link_d  = 1'b1;
          pv_d    = (kind_q == GC_KIND_POLL);
          kind_d  = GC_KIND_POLL;
          state_d = ST_WAIT_PERIOD;
        end else if (rsp_expired) begin
          fail = 1'b1;
        end
      end
      ST_WAIT_PERIOD: if (per_expired) state_d = ST_SEND;
      ST_BACKOFF:     if (rsp_expired) state_d = ST_SEND;
      default:        state_d = ST_IDLE;
    endcase

    if (fail) begin
      err_d = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
      if (retry_q + 8'd1 >= RETRY_MAX) begin
        link_d   = 1'b0;
        kind_d   = GC_KIND_PROBE;
        retry_d  = '0;
        rsp_load = 1'b1;
        rsp_val  = PERIOD_LD;
        state_d  = ST_BACKOFF;
      end else begin
        retry_d = retry_q + 8'd1;
        state_d = ST_SEND;
      end
    end

    // With enable low, whatever move is next lands in IDLE instead.
    if (!enable && state_d != state_q && state_d inside {ST_SEND, ST_WAIT_PERIOD, ST_BACKOFF}) begin
      state_d = ST_IDLE;
      link_d  = 1'b0;
      kind_d  = GC_KIND_PROBE;
    end
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= GC_KIND_PROBE;
      retry_q     <= '0;
      seen_busy_q <= 1'b0;
      tx_command  <= '0;
      tx_length   <= '0;
      tx_start    <= 1'b0;
      poll_valid  <= 1'b0;
      link_up     <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      retry_q     <= retry_d;
      seen_busy_q <= seen_d;
      tx_command  <= cmd_d;
      tx_length   <= len_d;
      tx_start    <= start_d;
      poll_valid  <= pv_d;
      link_up     <= link_d;
      err_count   <= err_d;
    end
  end

endmodule

// File: tb/tb_gc_poll_scheduler.sv
// tb/tb_gc_poll_scheduler.sv - directed self-checking bench for gc_poll_scheduler with a transmitter/response model
module tb_gc_poll_scheduler;

  localparam int DIV     = 2;
  localparam int PER     = 1000;
  localparam int TO      = 40;
  localparam int BUSY_US = 36;
  localparam int RX_US   = 20;
  localparam logic [24:0] ID_CMD = 25'h0000001;
`ifdef GC_RUMBLE_EN
  localparam logic [24:0] POLL_CMD = 25'h0800603;
`else
  localparam logic [24:0] POLL_CMD = 25'h0800601;
`endif

  logic        clk100mhz = 1'b0;
  logic        reset     = 1'b0;
  logic        enable    = 1'b0;
  logic        rumble    = 1'b0;
  logic        tx_busy   = 1'b0;
  logic        rx_done   = 1'b0;
  logic        rx_error  = 1'b0;
  logic [24:0] tx_command;
  logic [12:0] tx_length;
  logic        tx_start;
  logic        poll_valid;
  logic        link_up;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tx_cnt = 0, pv_cnt = 0, last_start = 0, prev_start = 0, busy_fall = 0;
  int busy_left = 0, resp_left = -1;
  int resp_mode = 0;  // 0 = rx_done, 1 = silent, 2 = rx_done with rx_error

  gc_poll_scheduler #(
    .CLK_HZ          (DIV * 1000000),
    .POLL_PERIOD_US  (PER),
    .RESP_TIMEOUT_US (TO),
    .MAX_RETRIES     (3)
  ) dut (
    .clk100mhz  (clk100mhz),
    .reset      (reset),
    .enable     (enable),
    .rumble     (rumble),
    .tx_command (tx_command),
    .tx_length  (tx_length),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .rx_done    (rx_done),
    .rx_error   (rx_error),
    .poll_valid (poll_valid),
    .link_up    (link_up),
    .err_count  (err_count)
  );

  always #5 clk100mhz = ~clk100mhz;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  // Transmitter busy for BUSY_US after each tx_start; controller answers RX_US after busy falls.
  initial begin
    forever begin
      @(negedge clk100mhz);
      rx_done  = 1'b0;
      rx_error = 1'b0;
      if (tx_start) begin
        tx_cnt++;
        prev_start = last_start;
        last_start = cyc;
        busy_left  = BUSY_US * DIV;
        tx_busy    = 1'b1;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy   = 1'b0;
          busy_fall = cyc;
          resp_left = RX_US * DIV;
        end
      end
      if (resp_left > 0) begin
        resp_left--;
        if (resp_left == 0) begin
          rx_done   = (resp_mode != 1);
          rx_error  = (resp_mode == 2);
          resp_left = -1;
        end
      end
      if (poll_valid) pv_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk100mhz);
    #1;
  endtask

  task automatic wait_tx(input string tag, input int bound);
    int old, n;
    old = tx_cnt;
    n = 0;
    while (tx_cnt == old && n < bound) begin tick(); n++; end
    check_val(tag, 32'(tx_cnt != old), 32'd1);
  endtask

  task automatic wait_link(input string tag, input logic val, input int bound);
    int n;
    n = 0;
    while (link_up !== val && n < bound) begin tick(); n++; end
    check_val(tag, 32'(link_up), 32'(val));
  endtask

  task automatic wait_err(input string tag, input logic [7:0] old, input int bound);
    int n;
    n = 0;
    while (err_count == old && n < bound) begin tick(); n++; end
    check_val(tag, 32'(err_count != old), 32'd1);
  endtask

  task automatic wait_pv(input string tag, input int old, input int bound);
    int n;
    n = 0;
    while (pv_cnt == old && n < bound) begin tick(); n++; end
    check_val(tag, pv_cnt, old + 1);
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  initial begin
    int n, fall_cyc, pv0, old_cnt;
    reset  = 1'b0;
    enable = 1'b1;
    rumble = 1'b1;
    repeat (5) tick();
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_poll_valid", 32'(poll_valid), 32'd0);
    check_val("rst_link_up", 32'(link_up), 32'd0);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    check_val("rst_tx_command", 32'(tx_command), 32'd0);
    check_val("rst_tx_length", 32'(tx_length), 32'd0);

    reset = 1'b1;
    n = 0;
    while (!tx_start && n < 10) begin tick(); n++; end
    check_val("probe_latency", n, 2);
    check_val("probe_cmd", 32'(tx_command), 32'(ID_CMD));
    check_val("probe_len", 32'(tx_length), 32'd9);

    wait_link("probe_link_up", 1'b1, 400);
    check_val("probe_no_pv", pv_cnt, 0);

    wait_tx("poll1_start", 2 * PER * DIV);
    check_val("poll1_cmd", 32'(tx_command), 32'(POLL_CMD));
    check_val("poll1_len", 32'(tx_length), 32'd25);
    check_val("poll1_period", 32'(in_rng(last_start - prev_start, PER * DIV, PER * DIV + 2 * DIV)), 32'd1);
    wait_pv("poll1_pv", 0, 400);

    wait_tx("poll2_start", 2 * PER * DIV);
    check_val("poll2_period", 32'(in_rng(last_start - prev_start, PER * DIV, PER * DIV + 2 * DIV)), 32'd1);
    resp_mode = 1;
    fall_cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      wait_err("noresp_err_step", 8'(k - 1), 400);
      check_val("noresp_err_count", 32'(err_count), k);
      check_val("noresp_link_up", 32'(link_up), 32'(k < 3));
      if (k < 3) begin
        wait_tx("noresp_retry", 400);
        check_val("noresp_retry_cmd", 32'(tx_command), 32'(POLL_CMD));
      end else begin
        fall_cyc = cyc;
        check_val("timeout_delay", 32'(in_rng(cyc - busy_fall, TO * DIV, TO * DIV + 2 * DIV)), 32'd1);
      end
    end
    resp_mode = 0;

    wait_tx("backoff_probe", 2 * PER * DIV);
    check_val("backoff_cmd", 32'(tx_command), 32'(ID_CMD));
    check_val("backoff_len", 32'(tx_length), 32'd9);
    check_val("backoff_time", 32'(in_rng(last_start - fall_cyc, PER * DIV, PER * DIV + 2 * DIV)), 32'd1);
    wait_link("relink_up", 1'b1, 400);

    wait_tx("dual_poll", 2 * PER * DIV);
    resp_mode = 2;
    pv0 = pv_cnt;
    wait_err("dual_err_step", 8'd3, 400);
    check_val("dual_err_count", 32'(err_count), 32'd4);
    check_val("dual_no_pv", pv_cnt, pv0);
    resp_mode = 0;
    wait_tx("dual_retry", 400);
    check_val("dual_retry_cmd", 32'(tx_command), 32'(POLL_CMD));
    check_val("dual_retry_fast", 32'(last_start - prev_start < PER * DIV), 32'd1);
    wait_pv("dual_retry_pv", pv0, 400);

    wait_tx("en_poll", 2 * PER * DIV);
    n = 0;
    while (tx_busy && n < 200) begin tick(); n++; end
    enable = 1'b0;
    pv0 = pv_cnt;
    wait_pv("en_off_pv", pv0, 400);
    repeat (2) tick();
    check_val("en_off_link", 32'(link_up), 32'd0);
    old_cnt = tx_cnt;
    repeat (3 * PER * DIV) tick();
    check_val("en_off_no_tx", tx_cnt, old_cnt);

    enable = 1'b1;
    n = 0;
    while (!tx_start && n < 20) begin tick(); n++; end
    check_val("rst_test_start", 32'(tx_start), 32'd1);
    reset = 1'b0;
    #1;
    check_val("midrst_tx_start", 32'(tx_start), 32'd0);
    check_val("midrst_tx_command", 32'(tx_command), 32'd0);
    check_val("midrst_tx_length", 32'(tx_length), 32'd0);
    check_val("midrst_err_count", 32'(err_count), 32'd0);
    check_val("midrst_link_up", 32'(link_up), 32'd0);
    check_val("midrst_poll_valid", 32'(poll_valid), 32'd0);
    tick();
    reset = 1'b1;
    wait_tx("rst_reprobe", 400);
    check_val("rst_reprobe_cmd", 32'(tx_command), 32'(ID_CMD));
    check_val("rst_reprobe_len", 32'(tx_length), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gc_poll_scheduler.md
# gc_poll_scheduler

Sequencer that owns the GameCube controller bit transmitter and decides what it sends and when. After reset it probes the controller with the ID command. Once a response arrives it issues the poll command at a fixed period, carrying the rumble request. It detects missing or bad responses, retries, and falls back to re-probing, and reports link state and error counts to the game logic.

## Interface
- CLK_HZ, 100000000: clock frequency, used to derive a 1 µs tick.
- POLL_PERIOD_US, 16000: poll start-to-start interval in µs.
- RESP_TIMEOUT_US, 400: maximum wait from transmitter idle to response.
- MAX_RETRIES, 3: consecutive failures before the link is declared down.
- clk100mhz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  allows probing and polling.
- rumble  in  1  rumble request; sampled in the cycle tx_start is asserted.
- tx_command  out  25  command word for the transmitter, MSB-first, stop bit in bit 0.
- tx_length  out  13  number of bits to send, including the stop bit.
- tx_start  out  1  one-cycle request to the transmitter.
- tx_busy  in  1  transmitter is driving the line.
- rx_done  in  1  one-cycle pulse: valid response received.
- rx_error  in  1  one-cycle pulse: malformed response.
- poll_valid  out  1  one-cycle pulse: poll response accepted.
- link_up  out  1  controller is responding.
- err_count  out  8  saturating count of failed transactions.

## Operation
- Command encodings:
  - ID: tx_command = 25'h0000001, tx_length = 9.
  - Poll: tx_command = {8'h40, 8'h03, 7'h00, rumble, 1'b1}, tx_length = 25.
- States: IDLE, SEND, WAIT_TX, WAIT_RX, WAIT_PERIOD, BACKOFF. A kind register (PROBE/POLL) selects which command SEND issues.
- IDLE:
  - link_up = 0 and kind = PROBE.
  - When enable = 1, go to SEND.
- SEND:
  - Wait for tx_busy = 0.
  - Then assert tx_start for one cycle with the command for the current kind, restart the period timer, and go to WAIT_TX.
- WAIT_TX:
  - Wait until tx_busy has been seen high and then low.
  - On the falling edge, load the timer with RESP_TIMEOUT_US and go to WAIT_RX.
  - If tx_busy is not seen high within 10 µs of tx_start, treat it as a failure.
- WAIT_RX:
  - rx_done: clear the retry count and set link_up = 1.
    - If kind = POLL, pulse poll_valid.
    - Set kind = POLL and go to WAIT_PERIOD.
  - rx_error or timeout: failure.
- Failure handling:
  - Increment err_count, saturating at 255, and increment the retry count.
  - If the retry count reaches MAX_RETRIES: set link_up = 0, kind = PROBE, clear the retry count, and go to BACKOFF.
  - Otherwise go to SEND and repeat the same command.
- WAIT_PERIOD: when the period timer expires, go to SEND.
- BACKOFF: wait POLL_PERIOD_US, then go to SEND (probe).
- enable deassert: an in-flight transaction (WAIT_TX, WAIT_RX) completes first. The next transition goes to IDLE instead of SEND, WAIT_PERIOD or BACKOFF.

## Timing
- Reset values:
  - tx_start = 0, poll_valid = 0, link_up = 0, err_count = 0.
  - tx_command = 0, tx_length = 0.
  - State = IDLE.
- All outputs are registered. tx_command and tx_length are valid in the tx_start cycle and held until the next SEND.
- Latency: enable rising to tx_start is 2 cycles when tx_busy = 0.
- Poll period is measured from tx_start to tx_start. Jitter is at most one µs tick.
- Simultaneous rx_done and rx_error: the error wins. rx_done or rx_error outside WAIT_RX is ignored.
- A timeout and rx_done in the same cycle count as success.
- The µs prescaler counts CLK_HZ/1000000 cycles. Timers are 16-bit down-counters; expiry is when the count reaches 0 on a tick.
- Asserting reset mid-transaction drops tx_start immediately. The transmitter is not otherwise notified.

## Configuration
- GC_RUMBLE_EN defined: the rumble input drives bit 1 of tx_command during polls.
- GC_RUMBLE_EN undefined: that bit is forced to 0. The rumble port remains present but is unused.

## Structure
- Shared package gc_pkg holds:
  - GC_CMD_W = 25 and GC_LEN_W = 13.
  - GC_CMD_ID = 8'h00 and GC_CMD_POLL = 16'h4003.
  - The state enum and the kind enum.
- One sub-module, gc_us_timer: µs prescaler plus a loadable 16-bit down-counter with an expired flag. Two instances:
  - response/backoff timer;
  - period timer.

## Test plan
- Reset released with enable = 1 and a transmitter model (busy for 36 µs):
  - tx_start with tx_command = 25'h1 and tx_length = 9.
  - rx_done at 20 µs → link_up = 1.
  - Next tx_start with tx_length = 25, 16000 µs after the first.
- Polling with rumble = 1 and GC_RUMBLE_EN defined → tx_command = 25'h0800603. Without the macro → 25'h0800601.
- No rx_done for three consecutive polls:
  - err_count = 1, 2, 3;
  - link_up falls after the third timeout at 400 µs;
  - after 16000 µs of backoff, an ID command is sent.
- rx_done and rx_error in the same WAIT_RX cycle → err_count increments, no poll_valid, same command retried.
- enable deasserted during WAIT_RX with rx_done later → poll_valid pulses, then IDLE, link_up = 0, no further tx_start.
- reset asserted during WAIT_TX → all outputs return to reset values within the same cycle. After release, the probe restarts.
